// File: rtl/adder_7b_reg.sv
// rtl/adder_7b_reg.sv - registered ripple-carry two's-complement adder
// Sum, carry and signed-overflow flags are captured only on qualified input cycles.
module adder_7b_reg #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             overflow,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  // Result registers hold across idle cycles; only the valid flag tracks in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S         <= '0;
      overflow  <= 1'b0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S        <= sum;
        cout     <= c[WIDTH];
        overflow <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_adder_7b_reg.sv
// tb/tb_adder_7b_reg.sv - scoreboard bench for adder_7b_reg
// Expected results come from integer arithmetic on the operands.
module tb_adder_7b_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [6:0] A = '0;
  logic [6:0] B = '0;
  logic       Cin = 1'b0;
  logic [6:0] S;
  logic       overflow;
  logic       cout;
  logic       out_valid;

  typedef struct packed {
    logic [6:0] s;
    logic       ov;
    logic       co;
  } exp_t;

  exp_t q[$];
  exp_t held = '0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_chk = 0;
  bit   mon_en = 1'b0;

  adder_7b_reg #(.WIDTH(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(A), .B(B), .Cin(Cin),
    .S(S), .overflow(overflow), .cout(cout), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [6:0] a, input logic [6:0] b, input logic c);
    exp_t m;
    int sa, sb, ua, ub, ss, us;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    us = ua + ub + int'(c);
    ss = sa + sb + int'(c);
    m.s  = us[6:0];
    m.co = (us >= 128);
    m.ov = (ss > 63) || (ss < -64);
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] a, input logic [6:0] b, input logic c, input logic v);
    @(negedge clk);
    A = a; B = b; Cin = c; in_valid = v;
    if (v) begin
      q.push_back(model(a, b, c));
      n_vec++;
    end
  endtask

  // Monitor: pop one expectation per out_valid; otherwise outputs must hold.
  always @(posedge clk) begin
    #1;
    if (mon_en && !rst) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_out_valid: got 1 expected 0 at %0t", $time);
        end else begin
          held = q.pop_front();
        end
      end
      chk("S", 32'(S), 32'(held.s));
      chk("overflow", 32'(overflow), 32'(held.ov));
      chk("cout", 32'(cout), 32'(held.co));
    end
  end

  initial begin
    #3;
    chk("reset_S", 32'(S), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_cout", 32'(cout), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    drive(7'b0001010, 7'b0010100, 1'b0, 1'b1);
    @(posedge clk); #2;
    chk("first_latency_out_valid", 32'(out_valid), 1);
    chk("first_latency_S", 32'(S), 32'(7'b0011110));
    drive(7'b1110110, 7'b0110010, 1'b0, 1'b1);
    drive(7'b1000100, 7'b0101011, 1'b0, 1'b1);
    drive(7'b1100000, 7'b1001101, 1'b0, 1'b1);
    drive(7'b1110011, 7'b1101000, 1'b0, 1'b1);
    drive(7'b0101000, 7'b0110010, 1'b0, 1'b1);
    drive(7'b0000000, 7'b0111000, 1'b0, 1'b1);
    drive(7'b0111111, 7'b0000000, 1'b1, 1'b1);
    drive(7'b1111111, 7'b1111111, 1'b1, 1'b0);
    drive(7'b0101010, 7'b0010101, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("drop_out_valid", 32'(out_valid), 0);
    chk("drop_hold_S", 32'(S), 32'(7'b1000000));
    chk("drop_hold_overflow", 32'(overflow), 1);

    // Reset mid-stream with a transaction already presented.
    drive(7'b0001111, 7'b0000001, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    q.delete();
    n_vec--;
    held = '0;
    #1;
    chk("async_rst_S", 32'(S), 0);
    chk("async_rst_overflow", 32'(overflow), 0);
    chk("async_rst_cout", 32'(cout), 0);
    chk("async_rst_out_valid", 32'(out_valid), 0);
    @(posedge clk); #2;
    chk("rst_wins_out_valid", 32'(out_valid), 0);
    chk("rst_wins_S", 32'(S), 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_no_pulse", 32'(out_valid), 0);

    drive(7'b0000011, 7'b0000100, 1'b0, 1'b1);
    @(posedge clk); #2;
    chk("post_rst_sample", 32'(S), 32'(7'b0000111));

    for (int i = 0; i < 400; i++) begin
      drive(7'($urandom), 7'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #2;
        A = 7'($urandom);
        B = 7'($urandom);
        Cin = 1'($urandom);
      end
    end
    drive(7'd0, 7'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_7b_reg.md
ADDER_7B_REG -- requirements
Module: adder_7b_reg

Interface
REQ-001 Parameter WIDTH, default 7, operand/result width; the design SHALL be verified at 7 only.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  A/B/Cin qualify this cycle.
REQ-005 A  input  7  two's-complement addend, range -64..63.
REQ-006 B  input  7  two's-complement addend, range -64..63.
REQ-007 Cin  input  1  carry-in added at bit 0; the common case ties it to 0.
REQ-008 S  output  7  registered two's-complement sum.
REQ-009 overflow  output  1  registered signed-overflow flag for S.
REQ-010 cout  output  1  registered unsigned carry out of bit 6.
REQ-011 out_valid  output  1  S/overflow/cout hold a new result this cycle.

Function
REQ-012 The adder SHALL be a ripple chain of 7 one-bit full adders: sum_i = A_i ^ B_i ^ c_i; c_(i+1) = A_i&B_i | c_i&(A_i^B_i); c_0 = Cin.
REQ-013 S SHALL equal (A + B + Cin) mod 128, with all 7 bits kept and no saturation (wrap-around).
REQ-014 cout SHALL equal c_7.
REQ-015 overflow SHALL equal c_7 XOR c_6, which is equivalent to A[6]==B[6] and S[6]!=A[6].
REQ-016 Latency: when in_valid=1 at clock edge N, S/overflow/cout SHALL update at edge N and out_valid SHALL be 1 for the following cycle.
REQ-017 When in_valid=0 at an edge, S/overflow/cout SHALL hold their values and out_valid SHALL go to 0.
REQ-018 Back-to-back in_valid SHALL produce one result per cycle, with no bubbles and no stall.
REQ-019 Inputs SHALL be sampled only at the rising edge; input changes between edges SHALL NOT affect the outputs.
REQ-020 The block SHALL have no output that depends combinationally on any input.
REQ-021 Inputs containing X/Z are out of scope; no checking is required.

Reset
REQ-022 While rst=1, S, overflow, cout and out_valid SHALL go to 0 immediately, independent of clk.
REQ-023 A transaction in flight when rst asserts SHALL be discarded, with no out_valid pulse after reset.
REQ-024 On the first rising edge after rst deasserts, the block SHALL sample normally.
REQ-025 If rst and in_valid are both high at an edge, reset SHALL win.

Verification
REQ-026 A=0001010 (10), B=0010100 (20), Cin=0 -> next cycle S=0011110 (30), overflow=0, cout=0, out_valid=1.
REQ-027 Mixed signs, no overflow:
- A=1110110 (-10), B=0110010 (50) -> S=0101000 (40), overflow=0, cout=1.
- A=1000100 (-60), B=0101011 (43) -> S=1101111 (-17), overflow=0, cout=0.
REQ-028 Negative overflow: A=1100000 (-32), B=1001101 (-51) -> S=0101101 (wraps to 45), overflow=1, cout=1.
REQ-029 Negative, no overflow: A=1110011 (-13), B=1101000 (-24) -> S=1011011 (-37), overflow=0, cout=1.
REQ-030 Positive overflow: A=0101000 (40), B=0110010 (50) -> S=1011010 (-38), overflow=1, cout=0.
REQ-031 Cin and control sequence:
- A=0000000, B=0111000 (56) -> S=0111000, overflow=0.
- A=0111111, B=0000000, Cin=1 -> S=1000000, overflow=1.
- Drop in_valid for 2 cycles -> outputs hold and out_valid=0.
- Assert rst mid-stream -> all outputs 0 asynchronously.
